// File: rtl/wb_arbiter_int_if.sv
// Write-back arbiter bus: result-source request side plus registered PRF
// write-port side. The arbiter connects through the slave modport. Result
// sources and PRF/scoreboard consumers connect through the master modport.
`ifndef PRF_INT_WAYS
`define PRF_INT_WAYS 4
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

interface wb_arbiter_int_if #(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = `PRF_INT_WAYS,
  parameter int IDX_W     = `PRF_INT_INDEX_SIZE,
  parameter int DATA_W    = 32
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0][IDX_W-1:0]    req_index;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_PORTS-1:0]             wb_valid;
  logic [NUM_PORTS-1:0][IDX_W-1:0]  wb_index;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wb_data;

  modport master (
    output req_valid, req_index, req_data,
    input  req_ready, wb_valid, wb_index, wb_data
  );

  modport slave (
    input  req_valid, req_index, req_data,
    output req_ready, wb_valid, wb_index, wb_data
  );
endinterface

// File: rtl/wb_arbiter_int.sv
// Integer PRF write-back arbiter.
// Shares NUM_PORTS write ports among NUM_REQ result sources. Selection is
// combinational from req_valid, and the chosen {index, data} pairs are
// registered onto the write ports. Source 0 has the highest priority.
// Optional starvation aging is enabled by defining WB_ARB_AGING_EN. With it
// defined, sources that have been denied for STARVE_LIMIT cycles are picked
// ahead of the others.
`ifndef PRF_INT_WAYS
`define PRF_INT_WAYS 4
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module wb_arbiter_int #(
  parameter int NUM_REQ      = 6,
  parameter int NUM_PORTS    = `PRF_INT_WAYS,
  parameter int IDX_W        = `PRF_INT_INDEX_SIZE,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input logic              clock,
  input logic              reset,
  input logic              clear,
  wb_arbiter_int_if.slave  bus
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // A zero limit would make every waiting source permanently urgent.
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("wb_arbiter_int: STARVE_LIMIT must be at least 1");
  end

  logic                            arb_en;
  logic [NUM_REQ-1:0]              urgent;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_PORTS-1:0]            sel_valid;
  logic [NUM_PORTS-1:0][IDX_W-1:0] sel_index;
  logic [NUM_PORTS-1:0][DATA_W-1:0] sel_data;

  logic [NUM_PORTS-1:0]             wb_valid_q;
  logic [NUM_PORTS-1:0][IDX_W-1:0]  wb_index_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wb_data_q;

  // Nothing is granted during reset or a flush. A result granted in such a
  // cycle would otherwise be lost.
  assign arb_en = reset & ~clear;

`ifdef WB_ARB_AGING_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REQ-1:0][CW-1:0] age;

  // Per-source starvation counter. It counts cycles waiting with no grant,
  // saturates at the limit, and restarts whenever the source stops waiting.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      age <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req_valid[i] || grant[i]) begin
          age[i] <= '0;
        end else if (age[i] != CW'(STARVE_LIMIT)) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  // A source is urgent once its counter has saturated.
  always_comb begin
    urgent = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      urgent[i] = (age[i] == CW'(STARVE_LIMIT));
    end
  end
`else
  // Strict fixed priority: no source is ever promoted.
  assign urgent = '0;
`endif

  // Two ascending scans. The first pass takes urgent sources and the second
  // takes the rest. Each pick fills the next free write port in order. With
  // aging disabled the first pass finds nothing.
  always_comb begin
    logic [PW-1:0] fill;
    logic          full;
    grant     = '0;
    sel_valid = '0;
    sel_index = '0;
    sel_data  = '0;
    fill      = '0;
    full      = 1'b0;
    if (arb_en) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.req_valid[i] && (urgent[i] == (pass == 0)) && !full) begin
            grant[i]        = 1'b1;
            sel_valid[fill] = 1'b1;
            sel_index[fill] = bus.req_index[i];
            sel_data[fill]  = bus.req_data[i];
            if (fill == PW'(NUM_PORTS - 1)) begin
              full = 1'b1;
            end else begin
              fill = fill + 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.req_ready = grant;

  // Write-port register stage. A flush leaves sel_valid empty, so the ports
  // go idle on the following cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wb_valid_q <= '0;
      wb_index_q <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= sel_valid;
      wb_index_q <= sel_index;
      wb_data_q  <= sel_data;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_index = wb_index_q;
  assign bus.wb_data  = wb_data_q;

endmodule
